serial_magnitude_comparator: RTL and testbench

//   Parametrised multi-bit successor to the one-bit comparator: compares two WIDTH-bit operands
//   bit-serially, MSB first, using a small FSM. Operands are captured on a start pulse. The

---
 rtl/serial_magnitude_comparator.sv | 161 ++++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//   Bit-serial, MSB-first magnitude comparator for two WIDTH-bit operands.
//   A start pulse in IDLE captures the operands. A two-state FSM (IDLE/CMP)
//   then walks the bits one per clock. The registered greater/equal/less
//   flags are updated together with a one-clock done pulse.
//   EARLY_EXIT=1 finishes on the first differing bit.
//   EARLY_EXIT=0 always takes WIDTH clocks.
//   Optional macro SIGNED_CMP_EN: treat operands as two's complement. The
//   sign bit then inverts the decision rule on the MSB step only.
module serial_magnitude_comparator #(
  parameter int WIDTH      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out1,
  output logic             out2,
  output logic             out3,
  output logic             done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CMP  = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_nextState;
  logic [WIDTH-1:0] r_shA;
  logic [WIDTH-1:0] r_shB;
  logic [CW-1:0]    r_bitCnt;
  logic             r_decided;
  logic             r_gt;
  logic             r_out1;
  logic             r_out2;
  logic             r_out3;
  logic             r_done;

  logic w_msbA;
  logic w_msbB;
  logic w_diff;
  logic w_bitGt;
  logic w_decidedNow;
  logic w_gtNow;
  logic w_lastBit;
  logic w_stop;
  logic w_load;
  logic w_advance;
  logic w_finish;

  assign w_msbA = r_shA[WIDTH-1];
  assign w_msbB = r_shB[WIDTH-1];
  assign w_diff = w_msbA ^ w_msbB;

`ifdef SIGNED_CMP_EN
  logic w_firstStep;
  // On the sign bit a 1 means negative, so the operand holding the 1 is the smaller one
  assign w_firstStep = (r_bitCnt == LAST_IDX);
  assign w_bitGt     = w_firstStep ? w_msbB : w_msbA;
`else
  assign w_bitGt     = w_msbA;
`endif

  // A decision taken on an earlier bit is frozen; later bits can no longer change it
  assign w_decidedNow = r_decided | w_diff;
  assign w_gtNow      = r_decided ? r_gt : w_bitGt;
  assign w_lastBit    = (r_bitCnt == '0);
  assign w_stop       = ((EARLY_EXIT != 0) && w_decidedNow) || w_lastBit;

  // FSM state register
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and datapath control strobes
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_advance   = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_nextState = CMP;
        end
      end
      CMP: begin
        if (w_stop) begin
          w_finish    = 1'b1;
          w_nextState = IDLE;
        end else begin
          w_advance   = 1'b1;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Operand shift registers, bit counter and the frozen decision
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_shA     <= '0;
      r_shB     <= '0;
      r_bitCnt  <= '0;
      r_decided <= 1'b0;
      r_gt      <= 1'b0;
    end else if (w_load) begin
      r_shA     <= in1;
      r_shB     <= in2;
      r_bitCnt  <= LAST_IDX;
      r_decided <= 1'b0;
      r_gt      <= 1'b0;
    end else if (w_advance) begin
      r_shA    <= r_shA << 1;
      r_shB    <= r_shB << 1;
      r_bitCnt <= r_bitCnt - CW'(1);
      if (!r_decided && w_diff) begin
        r_decided <= 1'b1;
        r_gt      <= w_bitGt;
      end
    end
  end

  // Result flags change only on a finishing edge; done pulses on that same edge
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_out1 <= 1'b0;
      r_out2 <= 1'b0;
      r_out3 <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish) begin
        r_out1 <= w_decidedNow & w_gtNow;
        r_out2 <= ~w_decidedNow;
        r_out3 <= w_decidedNow & ~w_gtNow;
      end
    end
  end

  assign out1 = r_out1;
  assign out2 = r_out2;
  assign out3 = r_out3;
  assign done = r_done;
  assign busy = (r_state == CMP);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Self-checking bench for serial_magnitude_comparator.
// Three instances: WIDTH=8 early-exit, WIDTH=8 fixed-latency, WIDTH=1.
module tb_serial_magnitude_comparator;

  logic clk;
  logic rstN;
  logic startE, startF, startW;
  logic [7:0] in1, in2;
  logic in1w, in2w;
  logic gtE, eqE, ltE, doneE, busyE;
  logic gtF, eqF, ltF, doneF, busyF;
  logic gtW, eqW, ltW, doneW, busyW;

  int checks = 0;
  int errors = 0;

  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(1)) dutEarly (
    .sys_clk(clk), .sys_rst_n(rstN), .start(startE), .in1(in1), .in2(in2),
    .out1(gtE), .out2(eqE), .out3(ltE), .done(doneE), .busy(busyE));

  serial_magnitude_comparator #(.WIDTH(8), .EARLY_EXIT(0)) dutFixed (
    .sys_clk(clk), .sys_rst_n(rstN), .start(startF), .in1(in1), .in2(in2),
    .out1(gtF), .out2(eqF), .out3(ltF), .done(doneF), .busy(busyF));

  serial_magnitude_comparator #(.WIDTH(1), .EARLY_EXIT(1)) dutBit (
    .sys_clk(clk), .sys_rst_n(rstN), .start(startW), .in1(in1w), .in2(in2w),
    .out1(gtW), .out2(eqW), .out3(ltW), .done(doneW), .busy(busyW));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: numeric ordering of the operands ({gt,eq,lt})
  function automatic logic [2:0] refRes(input logic [7:0] a, input logic [7:0] b, input int w);
    int va, vb;
    va = int'(a) & ((1 << w) - 1);
    vb = int'(b) & ((1 << w) - 1);
`ifdef SIGNED_CMP_EN
    if (va >= (1 << (w - 1))) va = va - (1 << w);
    if (vb >= (1 << (w - 1))) vb = vb - (1 << w);
`endif
    if (va > vb) return 3'b100;
    if (va == vb) return 3'b010;
    return 3'b001;
  endfunction

  // Reference model: clocks from start edge to done edge
  function automatic int refLatency(input logic [7:0] a, input logic [7:0] b, input int w, input bit early);
    if (!early) return w;
    for (int i = w - 1; i >= 0; i--) begin
      if (a[i] != b[i]) return w - i;
    end
    return w;
  endfunction

  task automatic setInputs(input int which, input logic [7:0] a, input logic [7:0] b);
    if (which == 2) begin
      in1w = a[0];
      in2w = b[0];
    end else begin
      in1 = a;
      in2 = b;
    end
  endtask

  task automatic setStart(input int which, input logic v);
    case (which)
      0: startE = v;
      1: startF = v;
      default: startW = v;
    endcase
  endtask

  task automatic getObs(input int which, output logic d, output logic bz, output logic [2:0] res);
    case (which)
      0: begin d = doneE; bz = busyE; res = {gtE, eqE, ltE}; end
      1: begin d = doneF; bz = busyF; res = {gtF, eqF, ltF}; end
      default: begin d = doneW; bz = busyW; res = {gtW, eqW, ltW}; end
    endcase
  endtask

  // Launch one comparison and wait (bounded) for its done; returns at the done-cycle negedge
  task automatic runOp(input int which, input bit immediate, input logic [7:0] a, input logic [7:0] b,
                       output int lat, output int busyCnt, output logic [2:0] res);
    logic d, bz;
    if (!immediate) @(negedge clk);
    setInputs(which, a, b);
    setStart(which, 1'b1);
    @(negedge clk);
    setStart(which, 1'b0);
    setInputs(which, 8'h5A, 8'hC3);
    lat = 0;
    busyCnt = 0;
    getObs(which, d, bz, res);
    while (!d && lat < 40) begin
      if (bz) busyCnt++;
      @(negedge clk);
      lat++;
      getObs(which, d, bz, res);
    end
    if (!d) lat = -1;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    startE = 1'b0; startF = 1'b0; startW = 1'b0;
    in1 = '0; in2 = '0; in1w = 1'b0; in2w = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({gtE, eqE, ltE, doneE, busyE} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_early: got %b expected 00000", {gtE, eqE, ltE, doneE, busyE});
    end
    checks++;
    if ({gtF, eqF, ltF, doneF, busyF, gtW, eqW, ltW, doneW, busyW} !== 10'b0) begin
      errors++;
      $display("[TB] FAIL reset_others: got %b expected 0", {gtF, eqF, ltF, doneF, busyF, gtW, eqW, ltW, doneW, busyW});
    end
    rstN = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_spec_vectors();
    int lat, bc;
    logic [2:0] res;
    runOp(0, 0, 8'hA5, 8'h25, lat, bc, res);
    checks++;
    if (lat !== 1 || res !== refRes(8'hA5, 8'h25, 8)) begin
      errors++;
      $display("[TB] FAIL msb_differs: got lat=%0d res=%b expected lat=1 res=%b", lat, res, refRes(8'hA5, 8'h25, 8));
    end
    runOp(0, 0, 8'h3C, 8'h3C, lat, bc, res);
    checks++;
    if (lat !== 8 || bc !== 8 || res !== 3'b010) begin
      errors++;
      $display("[TB] FAIL equal: got lat=%0d busy=%0d res=%b expected lat=8 busy=8 res=010", lat, bc, res);
    end
    @(negedge clk);
    checks++;
    if (doneE !== 1'b0) begin
      errors++;
      $display("[TB] FAIL done_pulse_width: got done=%b expected 0", doneE);
    end
    runOp(0, 0, 8'hFF, 8'h01, lat, bc, res);
    checks++;
`ifdef SIGNED_CMP_EN
    if (lat !== 1 || res !== 3'b001) begin
      errors++;
      $display("[TB] FAIL sign_bit: got lat=%0d res=%b expected lat=1 res=001", lat, res);
    end
`else
    if (lat !== 1 || res !== 3'b100) begin
      errors++;
      $display("[TB] FAIL sign_bit: got lat=%0d res=%b expected lat=1 res=100", lat, res);
    end
`endif
  endtask

  task automatic test_busy_ignore();
    int doneCnt = 0;
    int lat = -1;
    logic [2:0] res = 3'b000;
    @(negedge clk);
    in1 = 8'h10; in2 = 8'h11; startE = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      startE = (n == 2 || n == 5);
      if (n == 2) begin in1 = 8'hFF; in2 = 8'h00; end
      if (doneE) begin
        doneCnt++;
        if (lat < 0) begin lat = n - 1; res = {gtE, eqE, ltE}; end
      end
    end
    startE = 1'b0;
    checks++;
    if (doneCnt !== 1 || lat !== 8 || res !== 3'b001) begin
      errors++;
      $display("[TB] FAIL busy_ignore: got dones=%0d lat=%0d res=%b expected dones=1 lat=8 res=001", doneCnt, lat, res);
    end
  endtask

  task automatic test_hold();
    int lat, bc;
    logic [2:0] res;
    bit held = 1'b1;
    int n = 0;
    runOp(0, 0, 8'hA5, 8'h24, lat, bc, res);
    @(negedge clk);
    in1 = 8'h3C; in2 = 8'h3C; startE = 1'b1;
    @(negedge clk);
    startE = 1'b0;
    while (!doneE && n < 40) begin
      if ({gtE, eqE, ltE} !== res) held = 1'b0;
      @(negedge clk);
      n++;
    end
    checks++;
    if (!held || res !== refRes(8'hA5, 8'h24, 8)) begin
      errors++;
      $display("[TB] FAIL hold_during_cmp: got held=%b first=%b expected held=1 first=%b", held, res, refRes(8'hA5, 8'h24, 8));
    end
    checks++;
    if ({gtE, eqE, ltE} !== 3'b010 || n !== 8) begin
      errors++;
      $display("[TB] FAIL hold_then_update: got res=%b lat=%0d expected res=010 lat=8", {gtE, eqE, ltE}, n);
    end
  endtask

  task automatic test_reset_abort();
    int doneCnt = 0;
    @(negedge clk);
    in1 = 8'h00; in2 = 8'h80; startE = 1'b1;
    @(negedge clk);
    startE = 1'b0;
    rstN = 1'b0;
    @(negedge clk);
    checks++;
    if ({gtE, eqE, ltE, doneE, busyE} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_abort: got %b expected 00000", {gtE, eqE, ltE, doneE, busyE});
    end
    rstN = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (doneE) doneCnt++;
    end
    checks++;
    if (doneCnt !== 0 || {gtE, eqE, ltE} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL abort_no_done: got dones=%0d res=%b expected dones=0 res=000", doneCnt, {gtE, eqE, ltE});
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [2:0] res;
    logic [7:0] a, b;
    runOp(1, 0, 8'hA5, 8'h25, lat, bc, res);
    checks++;
    if (lat !== 8 || res !== refRes(8'hA5, 8'h25, 8)) begin
      errors++;
      $display("[TB] FAIL fixed_first: got lat=%0d res=%b expected lat=8 res=%b", lat, res, refRes(8'hA5, 8'h25, 8));
    end
    runOp(1, 1, 8'h01, 8'h02, lat, bc, res);
    checks++;
    if (lat !== 8 || res !== 3'b001) begin
      errors++;
      $display("[TB] FAIL fixed_back_to_back: got lat=%0d res=%b expected lat=8 res=001", lat, res);
    end
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      runOp(0, 1, a, b, lat, bc, res);
      checks++;
      if (lat !== refLatency(a, b, 8, 1) || res !== refRes(a, b, 8)) begin
        errors++;
        $display("[TB] FAIL early_back_to_back: a=%h b=%h got lat=%0d res=%b expected lat=%0d res=%b",
                 a, b, lat, res, refLatency(a, b, 8, 1), refRes(a, b, 8));
      end
    end
  endtask

  task automatic test_random();
    int lat, bc;
    logic [2:0] res;
    logic [7:0] a, b;
    int which;
    for (int i = 0; i < 36; i++) begin
      which = (i < 24) ? 0 : 1;
      a = 8'($urandom);
      case ($urandom_range(0, 3))
        0: b = a;
        1: b = a ^ (8'h01 << $urandom_range(0, 7));
        default: b = 8'($urandom);
      endcase
      runOp(which, 0, a, b, lat, bc, res);
      checks++;
      if (lat !== refLatency(a, b, 8, which == 0) || bc !== lat || res !== refRes(a, b, 8)) begin
        errors++;
        $display("[TB] FAIL random_cmp: inst=%0d a=%h b=%h got lat=%0d busy=%0d res=%b expected lat=%0d res=%b",
                 which, a, b, lat, bc, res, refLatency(a, b, 8, which == 0), refRes(a, b, 8));
      end
    end
  endtask

  task automatic test_width1();
    int lat, bc;
    logic [2:0] res;
    logic [7:0] a, b;
    for (int i = 0; i < 4; i++) begin
      a = 8'(i & 1);
      b = 8'((i >> 1) & 1);
      runOp(2, 0, a, b, lat, bc, res);
      checks++;
      if (lat !== 1 || res !== refRes(a, b, 1)) begin
        errors++;
        $display("[TB] FAIL width1: a=%0d b=%0d got lat=%0d res=%b expected lat=1 res=%b",
                 a[0], b[0], lat, res, refRes(a, b, 1));
      end
    end
  endtask

  initial begin
    test_reset();
    test_spec_vectors();
    test_busy_ignore();
    test_hold();
    test_reset_abort();
    test_back_to_back();
    test_random();
    test_width1();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
